// File: rtl/regread_issue_sched.sv
// regread_issue_sched: wakeup/select scheduler feeding the RegRead stage.
// Holds renamed instructions in IQ_DEPTH entries, tracks a per-preg ready
// scoreboard, and issues the oldest ready entry into a registered slot.
// Optional build macro WAKEUP_BYPASS_EN: the same-cycle writeback also feeds
// eligibility, so a woken entry issues one cycle earlier.
module regread_issue_sched #(
   parameter int unsigned NUM_PHYS_REGS = 64,
   parameter int unsigned IQ_DEPTH      = 8,
   localparam int unsigned PW = $clog2(NUM_PHYS_REGS),
   localparam int unsigned IW = $clog2(IQ_DEPTH),
   localparam int unsigned OW = 5,
   localparam int unsigned UW = 32
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          flush,
   input  logic          alloc_valid,
   output logic          alloc_ready,
   input  logic [UW-1:0] alloc_uid,
   input  logic [PW-1:0] alloc_rs,
   input  logic [PW-1:0] alloc_rt,
   input  logic [PW-1:0] alloc_rd,
   input  logic          alloc_use_rt,
   input  logic          alloc_wr_rd,
   input  logic          wb_valid,
   input  logic [PW-1:0] wb_reg,
   output logic          issue_valid,
   input  logic          issue_ready,
   output logic [UW-1:0] issue_uid,
   output logic [PW-1:0] issue_rs,
   output logic [PW-1:0] issue_rt,
   output logic [PW-1:0] issue_rd,
   output logic          iq_empty,
   output logic [OW-1:0] occupancy
);

   // entry storage
   logic [IQ_DEPTH-1:0] valid_q, valid_d;
   logic [IQ_DEPTH-1:0] use_rt_q, use_rt_d;
   logic [IQ_DEPTH-1:0] rs_rdy_q, rs_rdy_d;
   logic [IQ_DEPTH-1:0] rt_rdy_q, rt_rdy_d;
   logic [UW-1:0]       uid_q [IQ_DEPTH];
   logic [UW-1:0]       uid_d [IQ_DEPTH];
   logic [PW-1:0]       rs_q  [IQ_DEPTH];
   logic [PW-1:0]       rs_d  [IQ_DEPTH];
   logic [PW-1:0]       rt_q  [IQ_DEPTH];
   logic [PW-1:0]       rt_d  [IQ_DEPTH];
   logic [PW-1:0]       rd_q  [IQ_DEPTH];
   logic [PW-1:0]       rd_d  [IQ_DEPTH];
   // age_q[i][j] = 1 means entry i is older than entry j
   logic [IQ_DEPTH-1:0] age_q [IQ_DEPTH];
   logic [IQ_DEPTH-1:0] age_d [IQ_DEPTH];

   logic [NUM_PHYS_REGS-1:0] sb_q, sb_d;

   logic          issue_valid_q, issue_valid_d;
   logic [UW-1:0] issue_uid_q, issue_uid_d;
   logic [PW-1:0] issue_rs_q, issue_rs_d;
   logic [PW-1:0] issue_rt_q, issue_rt_d;
   logic [PW-1:0] issue_rd_q, issue_rd_d;
   logic [OW-1:0] occ_q, occ_d;

   logic [IQ_DEPTH-1:0] rs_hit, rt_hit, elig, win_oh;
   logic [IW-1:0]       win_idx, free_idx;
   logic                any_elig, blocked, alloc_fire, load;
   logic                new_rs_rdy, new_rt_rdy;

   assign alloc_ready = ~(&valid_q);
   assign alloc_fire  = alloc_valid & alloc_ready & ~flush;
   assign any_elig    = |elig;
   assign load        = (~issue_valid_q | issue_ready) & any_elig & ~flush;
   assign new_rs_rdy  = sb_q[alloc_rs] | (wb_valid & (wb_reg == alloc_rs));
   assign new_rt_rdy  = sb_q[alloc_rt] | (wb_valid & (wb_reg == alloc_rt));

   // writeback tag match against every entry's sources
   always_comb begin
      rs_hit = '0;
      rt_hit = '0;
      for (int i = 0; i < int'(IQ_DEPTH); i++) begin
         rs_hit[i] = wb_valid & (wb_reg == rs_q[i]);
         rt_hit[i] = wb_valid & (wb_reg == rt_q[i]);
      end
   end

   // eligibility: valid entries with all true sources ready
   always_comb begin
      elig = '0;
      for (int i = 0; i < int'(IQ_DEPTH); i++) begin
`ifdef WAKEUP_BYPASS_EN
         elig[i] = valid_q[i] & (rs_rdy_q[i] | rs_hit[i]) &
                   (rt_rdy_q[i] | rt_hit[i] | ~use_rt_q[i]);
`else
         elig[i] = valid_q[i] & rs_rdy_q[i] & (rt_rdy_q[i] | ~use_rt_q[i]);
`endif
      end
   end

   // oldest-eligible select through the age matrix
   always_comb begin
      win_oh  = '0;
      win_idx = '0;
      blocked = 1'b0;
      for (int i = 0; i < int'(IQ_DEPTH); i++) begin
         blocked = 1'b0;
         for (int j = 0; j < int'(IQ_DEPTH); j++) begin
            blocked = blocked | (elig[j] & age_q[j][i]);
         end
         win_oh[i] = elig[i] & ~blocked;
      end
      for (int i = 0; i < int'(IQ_DEPTH); i++) begin
         if (win_oh[i]) win_idx = IW'(i);
      end
   end

   // lowest free entry, from pre-edge state only
   always_comb begin
      free_idx = '0;
      for (int i = int'(IQ_DEPTH) - 1; i >= 0; i--) begin
         if (!valid_q[i]) free_idx = IW'(i);
      end
   end

   // entry, age and scoreboard next state
   always_comb begin
      valid_d  = valid_q;
      use_rt_d = use_rt_q;
      rs_rdy_d = rs_rdy_q | rs_hit;
      rt_rdy_d = rt_rdy_q | rt_hit;
      uid_d    = uid_q;
      rs_d     = rs_q;
      rt_d     = rt_q;
      rd_d     = rd_q;
      age_d    = age_q;
      sb_d     = sb_q;

      if (wb_valid) sb_d[wb_reg] = 1'b1;
      if (load) valid_d[win_idx] = 1'b0;

      if (alloc_fire) begin
         valid_d[free_idx]  = 1'b1;
         use_rt_d[free_idx] = alloc_use_rt;
         rs_rdy_d[free_idx] = new_rs_rdy;
         rt_rdy_d[free_idx] = new_rt_rdy;
         uid_d[free_idx]    = alloc_uid;
         rs_d[free_idx]     = alloc_rs;
         rt_d[free_idx]     = alloc_rt;
         rd_d[free_idx]     = alloc_rd;
         age_d[free_idx]    = '0;
         for (int j = 0; j < int'(IQ_DEPTH); j++) begin
            age_d[j][free_idx] = valid_q[j];
         end
         if (alloc_wr_rd && (alloc_rd != '0)) sb_d[alloc_rd] = 1'b0;
      end

      sb_d[0] = 1'b1;

      if (flush) begin
         valid_d = '0;
         sb_d    = '1;
      end
   end

   // issue slot next state and occupancy count
   always_comb begin
      issue_valid_d = issue_valid_q;
      issue_uid_d   = issue_uid_q;
      issue_rs_d    = issue_rs_q;
      issue_rt_d    = issue_rt_q;
      issue_rd_d    = issue_rd_q;
      occ_d         = '0;

      if (load) begin
         issue_valid_d = 1'b1;
         issue_uid_d   = uid_q[win_idx];
         issue_rs_d    = rs_q[win_idx];
         issue_rt_d    = rt_q[win_idx];
         issue_rd_d    = rd_q[win_idx];
      end else if (issue_ready) begin
         issue_valid_d = 1'b0;
      end

      if (flush) begin
         issue_valid_d = 1'b0;
         issue_uid_d   = '0;
         issue_rs_d    = '0;
         issue_rt_d    = '0;
         issue_rd_d    = '0;
      end

      for (int i = 0; i < int'(IQ_DEPTH); i++) begin
         occ_d = occ_d + OW'(valid_d[i]);
      end
   end

   // state registers
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         valid_q       <= '0;
         use_rt_q      <= '0;
         rs_rdy_q      <= '0;
         rt_rdy_q      <= '0;
         sb_q          <= '1;
         issue_valid_q <= 1'b0;
         issue_uid_q   <= '0;
         issue_rs_q    <= '0;
         issue_rt_q    <= '0;
         issue_rd_q    <= '0;
         occ_q         <= '0;
         for (int i = 0; i < int'(IQ_DEPTH); i++) begin
            uid_q[i] <= '0;
            rs_q[i]  <= '0;
            rt_q[i]  <= '0;
            rd_q[i]  <= '0;
            age_q[i] <= '0;
         end
      end else begin
         valid_q       <= valid_d;
         use_rt_q      <= use_rt_d;
         rs_rdy_q      <= rs_rdy_d;
         rt_rdy_q      <= rt_rdy_d;
         sb_q          <= sb_d;
         issue_valid_q <= issue_valid_d;
         issue_uid_q   <= issue_uid_d;
         issue_rs_q    <= issue_rs_d;
         issue_rt_q    <= issue_rt_d;
         issue_rd_q    <= issue_rd_d;
         occ_q         <= occ_d;
         for (int i = 0; i < int'(IQ_DEPTH); i++) begin
            uid_q[i] <= uid_d[i];
            rs_q[i]  <= rs_d[i];
            rt_q[i]  <= rt_d[i];
            rd_q[i]  <= rd_d[i];
            age_q[i] <= age_d[i];
         end
      end
   end

   assign issue_valid = issue_valid_q;
   assign issue_uid   = issue_uid_q;
   assign issue_rs    = issue_rs_q;
   assign issue_rt    = issue_rt_q;
   assign issue_rd    = issue_rd_q;
   assign iq_empty    = ~issue_valid_q;
   assign occupancy   = occ_q;

endmodule

// File: tb/tb_regread_issue_sched.sv
// Directed bench for regread_issue_sched; expectations follow the
// WAKEUP_BYPASS_EN build setting.
module tb_regread_issue_sched;

`ifdef WAKEUP_BYPASS_EN
   localparam logic [31:0] BYP = 32'd1;
`else
   localparam logic [31:0] BYP = 32'd0;
`endif
   localparam logic [31:0] NBYP = 32'd1 - BYP;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        flush = 1'b0;
   logic        alloc_valid = 1'b0;
   logic        alloc_ready;
   logic [31:0] alloc_uid = '0;
   logic [5:0]  alloc_rs = '0, alloc_rt = '0, alloc_rd = '0;
   logic        alloc_use_rt = 1'b0, alloc_wr_rd = 1'b0;
   logic        wb_valid = 1'b0;
   logic [5:0]  wb_reg = '0;
   logic        issue_valid;
   logic        issue_ready = 1'b1;
   logic [31:0] issue_uid;
   logic [5:0]  issue_rs, issue_rt, issue_rd;
   logic        iq_empty;
   logic [4:0]  occupancy;

   int n_checks = 0;
   int n_errors = 0;

   regread_issue_sched dut (
      .CLK(CLK), .RESET(RESET), .flush(flush),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_uid(alloc_uid),
      .alloc_rs(alloc_rs), .alloc_rt(alloc_rt), .alloc_rd(alloc_rd),
      .alloc_use_rt(alloc_use_rt), .alloc_wr_rd(alloc_wr_rd),
      .wb_valid(wb_valid), .wb_reg(wb_reg),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_uid(issue_uid),
      .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_rd(issue_rd),
      .iq_empty(iq_empty), .occupancy(occupancy)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_alloc(input logic [31:0] uid, input logic [5:0] rs, input logic [5:0] rt,
                            input logic [5:0] rd, input logic use_rt, input logic wr_rd);
      alloc_valid  = 1'b1;
      alloc_uid    = uid;
      alloc_rs     = rs;
      alloc_rt     = rt;
      alloc_rd     = rd;
      alloc_use_rt = use_rt;
      alloc_wr_rd  = wr_rd;
   endtask

   task automatic no_alloc();
      alloc_valid = 1'b0;
   endtask

   task automatic flush_pulse();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_occ", 32'(occupancy), 0);
      check("flush_iv", 32'(issue_valid), 0);
   endtask

   initial begin
      // reset values
      #12;
      check("rst_iv", 32'(issue_valid), 0);
      check("rst_empty", 32'(iq_empty), 1);
      check("rst_occ", 32'(occupancy), 0);
      check("rst_ar", 32'(alloc_ready), 1);
      check("rst_uid", issue_uid, 0);
      @(negedge CLK);
      RESET = 1'b1;
      tick();

      // 1: single ready instruction
      set_alloc(1, 3, 4, 10, 1'b1, 1'b1);
      tick();
      no_alloc();
      check("t1_occ_a", 32'(occupancy), 1);
      check("t1_iv_a", 32'(issue_valid), 0);
      tick();
      check("t1_iv", 32'(issue_valid), 1);
      check("t1_uid", issue_uid, 1);
      check("t1_rd", 32'(issue_rd), 10);
      check("t1_rs", 32'(issue_rs), 3);
      check("t1_rt", 32'(issue_rt), 4);
      check("t1_occ", 32'(occupancy), 0);
      check("t1_empty", 32'(iq_empty), 0);
      tick();
      check("t1_drain", 32'(issue_valid), 0);
      flush_pulse();

      // 2: dependant waits for writeback of preg 10
      set_alloc(2, 0, 0, 10, 1'b0, 1'b1);
      tick();
      set_alloc(3, 10, 0, 20, 1'b0, 1'b1);
      tick();
      no_alloc();
      check("t2_uidA", issue_uid, 2);
      check("t2_occ", 32'(occupancy), 1);
      tick();
      check("t2_wait1", 32'(issue_valid), 0);
      tick();
      check("t2_wait2", 32'(issue_valid), 0);
      wb_valid = 1'b1;
      wb_reg   = 6'd10;
      tick();
      wb_valid = 1'b0;
      check("t2_iv_w", 32'(issue_valid), BYP);
      tick();
      check("t2_iv_w1", 32'(issue_valid), NBYP);
      check("t2_uidB", issue_uid, 3);
      check("t2_occ0", 32'(occupancy), 0);
      set_alloc(4, 10, 0, 0, 1'b0, 1'b0);
      tick();
      no_alloc();
      tick();
      check("t2_sb10_iv", 32'(issue_valid), 1);
      check("t2_sb10_uid", issue_uid, 4);
      flush_pulse();

      // 3: fill with blocked entries, wake one
      set_alloc(100, 0, 0, 30, 1'b0, 1'b1);
      tick();
      set_alloc(101, 0, 0, 31, 1'b0, 1'b1);
      tick();
      for (int k = 0; k < 8; k++) begin
         set_alloc(32'(200 + k), (k == 7) ? 6'd31 : 6'd30, 0, 0, 1'b0, 1'b0);
         tick();
      end
      no_alloc();
      check("t3_full_occ", 32'(occupancy), 8);
      check("t3_full_ar", 32'(alloc_ready), 0);
      check("t3_full_iv", 32'(issue_valid), 0);
      wb_valid = 1'b1;
      wb_reg   = 6'd31;
      tick();
      wb_valid = 1'b0;
      check("t3_w_iv", 32'(issue_valid), BYP);
      check("t3_w_occ", 32'(occupancy), 32'd8 - BYP);
      check("t3_w_ar", 32'(alloc_ready), BYP);
      tick();
      check("t3_s_uid", issue_uid, 207);
      check("t3_s_iv", 32'(issue_valid), NBYP);
      check("t3_s_occ", 32'(occupancy), 7);
      check("t3_s_ar", 32'(alloc_ready), 1);
      flush_pulse();

      // 4: age order across non-ascending slots, slot hold
      issue_ready = 1'b0;
      set_alloc(90, 0, 0, 0, 1'b0, 1'b0);
      tick();
      set_alloc(91, 0, 0, 0, 1'b0, 1'b0);
      tick();
      check("t4_e1_uid", issue_uid, 90);
      check("t4_e1_occ", 32'(occupancy), 1);
      set_alloc(92, 0, 0, 0, 1'b0, 1'b0);
      tick();
      check("t4_e2_uid", issue_uid, 90);
      set_alloc(5, 0, 0, 0, 1'b0, 1'b0);
      tick();
      check("t4_e3_occ", 32'(occupancy), 3);
      issue_ready = 1'b1;
      set_alloc(6, 0, 0, 0, 1'b0, 1'b0);
      tick();
      check("t4_e4_uid", issue_uid, 91);
      issue_ready = 1'b0;
      set_alloc(7, 0, 0, 0, 1'b0, 1'b0);
      tick();
      no_alloc();
      check("t4_e5_occ", 32'(occupancy), 4);
      check("t4_e5_uid", issue_uid, 91);
      issue_ready = 1'b1;
      tick();
      check("t4_ord_92", issue_uid, 92);
      tick();
      check("t4_ord_5", issue_uid, 5);
      issue_ready = 1'b0;
      tick();
      check("t4_hold1", issue_uid, 5);
      check("t4_hold1_iv", 32'(issue_valid), 1);
      tick();
      check("t4_hold2", issue_uid, 5);
      check("t4_hold_occ", 32'(occupancy), 2);
      issue_ready = 1'b1;
      tick();
      check("t4_ord_6", issue_uid, 6);
      tick();
      check("t4_ord_7", issue_uid, 7);
      tick();
      check("t4_drain", 32'(issue_valid), 0);
      flush_pulse();

      // 5: same-cycle set+clear of preg 12, rd=0 producer
      set_alloc(70, 0, 0, 12, 1'b0, 1'b1);
      wb_valid = 1'b1;
      wb_reg   = 6'd12;
      tick();
      wb_valid = 1'b0;
      set_alloc(71, 12, 0, 0, 1'b0, 1'b0);
      tick();
      no_alloc();
      check("t5_uid70", issue_uid, 70);
      tick();
      check("t5_blk1", 32'(issue_valid), 0);
      check("t5_blk_occ", 32'(occupancy), 1);
      tick();
      check("t5_blk2", 32'(issue_valid), 0);
      set_alloc(72, 0, 0, 0, 1'b0, 1'b1);
      tick();
      set_alloc(73, 0, 0, 0, 1'b1, 1'b0);
      tick();
      no_alloc();
      check("t5_uid72", issue_uid, 72);
      tick();
      check("t5_uid73", issue_uid, 73);
      wb_valid = 1'b1;
      wb_reg   = 6'd12;
      tick();
      wb_valid = 1'b0;
      check("t5_w_iv", 32'(issue_valid), BYP);
      tick();
      check("t5_w1_iv", 32'(issue_valid), NBYP);
      check("t5_uid71", issue_uid, 71);
      check("t5_occ0", 32'(occupancy), 0);
      flush_pulse();

      // 6: flush with live entries and same-cycle alloc, then async reset
      issue_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         set_alloc(32'(80 + k), 0, 0, 0, 1'b0, 1'b0);
         tick();
      end
      check("t6_pre_occ", 32'(occupancy), 4);
      check("t6_pre_iv", 32'(issue_valid), 1);
      flush    = 1'b1;
      wb_valid = 1'b1;
      wb_reg   = 6'd5;
      set_alloc(89, 0, 0, 0, 1'b0, 1'b0);
      tick();
      flush    = 1'b0;
      wb_valid = 1'b0;
      no_alloc();
      check("t6_occ", 32'(occupancy), 0);
      check("t6_iv", 32'(issue_valid), 0);
      check("t6_empty", 32'(iq_empty), 1);
      check("t6_ar", 32'(alloc_ready), 1);
      tick();
      check("t6_occ2", 32'(occupancy), 0);
      check("t6_iv2", 32'(issue_valid), 0);
      issue_ready = 1'b1;
      set_alloc(95, 0, 0, 0, 1'b0, 1'b0);
      tick();
      set_alloc(96, 7, 0, 0, 1'b0, 1'b0);
      tick();
      no_alloc();
      check("t6_live_iv", 32'(issue_valid), 1);
      check("t6_live_uid", issue_uid, 95);
      check("t6_live_occ", 32'(occupancy), 1);
      #2;
      RESET = 1'b0;
      #1;
      check("t6_rst_iv", 32'(issue_valid), 0);
      check("t6_rst_uid", issue_uid, 0);
      check("t6_rst_rd", 32'(issue_rd), 0);
      check("t6_rst_empty", 32'(iq_empty), 1);
      check("t6_rst_occ", 32'(occupancy), 0);
      check("t6_rst_ar", 32'(alloc_ready), 1);
      @(negedge CLK);
      RESET = 1'b1;
      tick();
      check("t6_post_iv", 32'(issue_valid), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
